// File: rtl/imem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imem_arbiter : two-master arbiter for a single-port program memory with an
//                bounded exclusive-lock mode for m1.   Rev 1.0
// ---------------------------------------------------------------------------
module imem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req_i,
  input  logic [AW-1:0] m0_addr_i,
  output logic          m0_gnt_o,
  output logic          m0_rvalid_o,
  output logic [DW-1:0] m0_rdata_o,
  input  logic          m1_req_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_wdata_i,
  input  logic          m1_lock_i,
  output logic          m1_gnt_o,
  output logic          m1_rvalid_o,
  output logic [DW-1:0] m1_rdata_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_e;

  localparam int            CW       = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_LOCK - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          lock_block_q, lock_block_d;
  logic          last_gnt_q, last_gnt_d;   // 1 = m1 granted most recently
  logic          m0_rvalid_q, m1_rvalid_q;
  logic          m0_gnt, m1_gnt, forced_exit;

  always_comb begin
    state_d      = state_q;
    lock_cnt_d   = lock_cnt_q;
    lock_block_d = lock_block_q;
    last_gnt_d   = last_gnt_q;
    m0_gnt       = 1'b0;
    m1_gnt       = 1'b0;
    forced_exit  = 1'b0;
    if (!rst) begin
      case (state_q)
        ARB: begin
          if (m0_req_i && m1_req_i) begin
            m0_gnt = last_gnt_q;
            m1_gnt = !last_gnt_q;
          end else begin
            m0_gnt = m0_req_i;
            m1_gnt = m1_req_i;
          end
          if (m1_gnt && m1_lock_i && !lock_block_q) begin
            state_d    = LOCK;
            lock_cnt_d = CNT_ONE;
          end
        end
        LOCK: begin
          m1_gnt     = m1_req_i;
          lock_cnt_d = lock_cnt_q + CNT_ONE;
          // The dropping cycle and the limit cycle both remain exclusive to m1.
          if (lock_cnt_q == CNT_LAST) begin
            state_d     = ARB;
            lock_cnt_d  = '0;
            forced_exit = 1'b1;
          end else if (!m1_lock_i) begin
            state_d    = ARB;
            lock_cnt_d = '0;
          end
        end
        default: state_d = ARB;
      endcase
      if (m0_gnt) last_gnt_d = 1'b0;
      if (m1_gnt) last_gnt_d = 1'b1;
      if (m0_gnt || !m0_req_i) lock_block_d = 1'b0;
      if (forced_exit) begin
        lock_block_d = 1'b1;
        last_gnt_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB;
      lock_cnt_q   <= '0;
      lock_block_q <= 1'b0;
      last_gnt_q   <= 1'b1;
      m0_rvalid_q  <= 1'b0;
      m1_rvalid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      lock_block_q <= lock_block_d;
      last_gnt_q   <= last_gnt_d;
      m0_rvalid_q  <= m0_gnt;
      m1_rvalid_q  <= m1_gnt && !m1_we_i;
    end
  end

  assign m0_gnt_o    = m0_gnt;
  assign m1_gnt_o    = m1_gnt;
  assign mem_req_o   = m0_gnt | m1_gnt;
  assign mem_we_o    = m1_gnt & m1_we_i;
  assign mem_addr_o  = m1_gnt ? m1_addr_i : (m0_gnt ? m0_addr_i : '0);
  assign mem_wdata_o = m1_gnt ? m1_wdata_i : '0;

  assign m0_rvalid_o = m0_rvalid_q;
  assign m1_rvalid_o = m1_rvalid_q;
  assign m0_rdata_o  = m0_rvalid_q ? mem_rdata_i : '0;
  assign m1_rdata_o  = m1_rvalid_q ? mem_rdata_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_imem_arbiter : directed + random bench for imem_arbiter against a
//                   cycle-level reference model.   Rev 1.0
// ---------------------------------------------------------------------------
module tb_imem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAX_LOCK = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req_i, m1_req_i, m1_we_i, m1_lock_i;
  logic [AW-1:0] m0_addr_i, m1_addr_i, mem_addr_o;
  logic [DW-1:0] m1_wdata_i, mem_wdata_o, mem_rdata_i, m0_rdata_o, m1_rdata_o;
  logic          m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, mem_req_o, mem_we_o;

  imem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_gnt_o(m0_gnt_o),
    .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
    .m1_wdata_i(m1_wdata_i), .m1_lock_i(m1_lock_i), .m1_gnt_o(m1_gnt_o),
    .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: memory contents plus arbitration history.
  logic [31:0] mem [32];
  bit          m_excl = 1'b0;   // m1 currently owns the memory exclusively
  int          m_run = 0;       // exclusive cycles used in the current lock
  bit          m_last = 1'b1;   // 1 = m1 was the most recent winner
  bit          m_block = 1'b0;  // m1 may not re-lock yet
  bit          m_pend0 = 1'b0, m_pend1 = 1'b0;
  logic [31:0] m_resp = '0;

  // Observed outputs of the most recent cycle, for directed checks.
  logic        o_g0, o_g1, o_rv0, o_rv1, o_we;
  logic [31:0] o_rd0, o_rd1, o_addr, o_wd;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  task automatic step(input bit r, input bit q0, input logic [31:0] a0,
                      input bit q1, input bit we, input logic [31:0] a1,
                      input logic [31:0] wd, input bit lk);
    bit e0, e1, enter;
    @(posedge clk);
    #1;
    rst = r; m0_req_i = q0; m0_addr_i = a0; m1_req_i = q1; m1_we_i = we;
    m1_addr_i = a1; m1_wdata_i = wd; m1_lock_i = lk;
    mem_rdata_i = (m_pend0 || m_pend1) ? m_resp : $urandom;
    @(negedge clk);
    e0 = 1'b0; e1 = 1'b0;
    if (!r) begin
      if (m_excl) e1 = q1;
      else if (q0 && q1) begin e0 = m_last; e1 = !m_last; end
      else begin e0 = q0; e1 = q1; end
    end
    check_eq("m0_gnt", m0_gnt_o, e0);
    check_eq("m1_gnt", m1_gnt_o, e1);
    check_eq("mem_req", mem_req_o, e0 | e1);
    check_eq("mem_we", mem_we_o, e1 & we);
    check_eq("mem_addr", mem_addr_o, e1 ? a1 : (e0 ? a0 : 32'h0));
    check_eq("mem_wdata", mem_wdata_o, e1 ? wd : 32'h0);
    check_eq("m0_rvalid", m0_rvalid_o, m_pend0);
    check_eq("m0_rdata", m0_rdata_o, m_pend0 ? m_resp : 32'h0);
    check_eq("m1_rvalid", m1_rvalid_o, m_pend1);
    check_eq("m1_rdata", m1_rdata_o, m_pend1 ? m_resp : 32'h0);
    o_g0 = m0_gnt_o; o_g1 = m1_gnt_o; o_rv0 = m0_rvalid_o; o_rv1 = m1_rvalid_o;
    o_we = mem_we_o; o_rd0 = m0_rdata_o; o_rd1 = m1_rdata_o;
    o_addr = mem_addr_o; o_wd = mem_wdata_o;
    // Advance the model across the coming rising edge.
    if (r) begin
      m_excl = 1'b0; m_run = 0; m_last = 1'b1; m_block = 1'b0;
      m_pend0 = 1'b0; m_pend1 = 1'b0;
    end else begin
      m_pend0 = e0;
      m_pend1 = e1 && !we;
      if (e0) m_resp = mem[a0[4:0]];
      else if (e1 && !we) m_resp = mem[a1[4:0]];
      if (e1 && we) mem[a1[4:0]] = wd;
      enter = !m_excl && e1 && lk && !m_block;
      if (e0) m_last = 1'b0;
      if (e1) m_last = 1'b1;
      if (e0 || !q0) m_block = 1'b0;
      if (m_excl) begin
        m_run++;
        if (m_run == MAX_LOCK) begin
          m_excl = 1'b0; m_block = 1'b1; m_last = 1'b1;
        end else if (!lk) begin
          m_excl = 1'b0;
        end
      end else if (enter) begin
        m_excl = 1'b1; m_run = 1;
      end
    end
  endtask

  initial begin
    bit lk_r;
    rst = 1'b1; m0_req_i = 0; m0_addr_i = 0; m1_req_i = 0; m1_we_i = 0;
    m1_addr_i = 0; m1_wdata_i = 0; m1_lock_i = 0; mem_rdata_i = 0;
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    mem[4] = 32'h0000_0013;
    repeat (2) @(posedge clk);

    // Reset state
    step(1, 0, 0, 0, 0, 0, 0, 0);

    // Lone m0 fetch with response next cycle
    step(0, 1, 32'h4, 0, 0, 0, 0, 0);
    check_eq("fetch_gnt", o_g0, 1'b1);
    check_eq("fetch_addr", o_addr, 32'h4);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("fetch_rvalid", o_rv0, 1'b1);
    check_eq("fetch_rdata", o_rd0, 32'h13);
    check_eq("fetch_m1_quiet", {o_g1, o_rv1, o_rd1}, '0);

    // Round-robin after reset: m0, m1, m0, m1
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, i, 1, 0, i + 8, 0, 0);
      check_eq("rr_m0", o_g0, (i % 2) == 0);
      check_eq("rr_m1", o_g1, (i % 2) == 1);
    end

    // Forced lock exit after MAX_LOCK cycles
    step(0, 1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < MAX_LOCK; i++) begin
      step(0, 1, 2, 1, 0, 3, 0, 1);
      check_eq("lock_m1", o_g1, 1'b1);
    end
    step(0, 1, 2, 1, 0, 3, 0, 1);
    check_eq("lock_limit_m0", o_g0, 1'b1);
    step(0, 1, 2, 1, 0, 3, 0, 0);
    check_eq("lock_rr_m1", o_g1, 1'b1);

    // m1 write
    step(0, 0, 0, 1, 1, 32'h10, 32'hDEAD_BEEF, 0);
    check_eq("wr_we", o_we, 1'b1);
    check_eq("wr_addr", o_addr, 32'h10);
    check_eq("wr_data", o_wd, 32'hDEAD_BEEF);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("wr_no_rvalid", o_rv1, 1'b0);

    // Voluntary lock release keeps one more exclusive cycle
    step(0, 0, 0, 1, 0, 5, 0, 1);
    step(0, 1, 6, 1, 0, 5, 0, 1);
    check_eq("drop_hold1", o_g1, 1'b1);
    step(0, 1, 6, 1, 0, 5, 0, 0);
    check_eq("drop_excl_m1", o_g1, 1'b1);
    check_eq("drop_excl_m0", o_g0, 1'b0);
    step(0, 1, 6, 1, 0, 5, 0, 0);
    check_eq("drop_arb_m0", o_g0, 1'b1);

    // Reset discards in-flight read response
    step(0, 1, 7, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("rst_drop_rvalid", o_rv0, 1'b0);
    step(0, 1, 8, 1, 0, 9, 0, 0);
    check_eq("rst_first_m0", o_g0, 1'b1);

    // Random traffic
    lk_r = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) lk_r = !lk_r;
      step($urandom_range(0, 79) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 31),
           $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 31),
           $urandom, lk_r);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
